// File: rtl/udma_ethernet_pkg.sv
// Shared types for the udma_ethernet receive and transmit AXI-Stream handlers.
// Frame lengths are 11 bits, which is enough for frames up to 2047 bytes.
package udma_ethernet_pkg;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_RECV,
        WR_DROP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

    typedef logic [10:0] frame_len_t;

    localparam int MAX_FRAME_LEN_LIMIT = 2047;

endpackage

// File: rtl/udma_ethernet_len_fifo.sv
// Small synchronous FIFO of frame lengths with full/empty flags and a first-word-fall-through read port.
// Pushes while full and pops while empty are ignored.
module udma_ethernet_len_fifo
    import udma_ethernet_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        push_i,
    input  logic [10:0] data_i,
    input  logic        pop_i,
    output logic [10:0] data_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(DEPTH);

    frame_len_t      mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/udma_ethernet_axis_rx_frame_buffer.sv
// Store-and-forward RX buffer between the MAC AXI-Stream output and the UDMA RX channel.
// Whole good frames are committed, then replayed byte-by-byte behind a length announcement.
module udma_ethernet_axis_rx_frame_buffer
    import udma_ethernet_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BUF_DEPTH      = 2048,
    parameter int LEN_FIFO_DEPTH = 8,
    parameter int MAX_FRAME_LEN  = 1522
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
    input  logic                  rx_axis_tvalid,
    output logic                  rx_axis_tready,
    input  logic                  rx_axis_tlast,
    input  logic                  rx_axis_tuser,
    output logic [DATA_WIDTH-1:0] data_rx_o,
    output logic                  data_rx_valid_o,
    input  logic                  data_rx_ready_i,
    output logic [10:0]           rx_transfer_size,
    output logic                  rx_frame_start_o,
    output logic [15:0]           rx_drop_cnt_o,
    output logic                  rx_busy_o
);
    localparam int AW        = $clog2(BUF_DEPTH);
    localparam int PW        = AW + 1;
    localparam int MAX_LEN_I = (MAX_FRAME_LEN > MAX_FRAME_LEN_LIMIT) ? MAX_FRAME_LEN_LIMIT : MAX_FRAME_LEN;
    localparam logic [PW-1:0] BUF_FULL = PW'(BUF_DEPTH);
    localparam logic [11:0]   MAX_LEN  = 12'(MAX_LEN_I);
    localparam logic [11:0]   LEN_SAT  = 12'(MAX_LEN_I + 1);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  ram_vld_q;

    wr_state_t             wr_state_q;
    rd_state_t             rd_state_q;
    logic [PW-1:0]         wr_cur_q;
    logic [PW-1:0]         wr_commit_q;
    logic [PW-1:0]         rd_q;
    logic [11:0]           len_q;
    logic [11:0]           len_d;
    logic [15:0]           drop_cnt_q;

    frame_len_t            size_q;
    frame_len_t            issue_cnt_q;
    frame_len_t            sent_cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  start_q;
    logic                  busy_q;

    logic                  buf_full;
    logic                  overflow;
    logic                  accept;
    logic                  commit;
    logic                  drop_evt;
    logic                  len_full;
    logic                  len_empty;
    logic                  len_pop;
    frame_len_t            len_dout;
    logic                  xfer;
    logic                  out_load;
    logic                  rd_issue;

    // The MAC cannot be stalled, so overflow is handled by dropping frames instead.
    assign rx_axis_tready   = 1'b1;
    assign data_rx_o        = data_q;
    assign data_rx_valid_o  = valid_q;
    assign rx_transfer_size = size_q;
    assign rx_frame_start_o = start_q;
    assign rx_drop_cnt_o    = drop_cnt_q;
    assign rx_busy_o        = busy_q;

    always_comb begin
        buf_full = ((wr_cur_q - rd_q) == BUF_FULL);
        len_d    = (wr_state_q == WR_IDLE) ? 12'd1 : ((len_q == LEN_SAT) ? len_q : len_q + 12'd1);
        overflow = buf_full || ((wr_state_q == WR_RECV) && (len_q == MAX_LEN));
        accept   = rx_axis_tvalid && (wr_state_q != WR_DROP) && !overflow;
        commit   = accept && rx_axis_tlast && !rx_axis_tuser && !len_full;
        drop_evt = rx_axis_tvalid && (wr_state_q != WR_DROP) && (overflow || (rx_axis_tlast && !commit));
        xfer     = valid_q && data_rx_ready_i;
        out_load = ram_vld_q && (!valid_q || data_rx_ready_i);
        rd_issue = (rd_state_q == RD_STREAM) && (issue_cnt_q != size_q) && (!ram_vld_q || out_load);
        len_pop  = (rd_state_q == RD_IDLE) && !len_empty;
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q[wr_cur_q[AW-1:0]] <= rx_axis_tdata;
        end
        if (rd_issue) begin
            ram_q <= mem_q[rd_q[AW-1:0]];
        end
    end

    // A rejected frame rewinds wr_cur so its bytes are overwritten by the next frame.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_state_q  <= WR_IDLE;
            wr_cur_q    <= '0;
            wr_commit_q <= '0;
            len_q       <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (rx_axis_tvalid) begin
                case (wr_state_q)
                    WR_IDLE, WR_RECV: begin
                        if (overflow) begin
                            wr_cur_q   <= wr_commit_q;
                            wr_state_q <= rx_axis_tlast ? WR_IDLE : WR_DROP;
                        end else if (rx_axis_tlast) begin
                            len_q      <= len_d;
                            wr_state_q <= WR_IDLE;
                            if (commit) begin
                                wr_cur_q    <= wr_cur_q + PW'(1);
                                wr_commit_q <= wr_cur_q + PW'(1);
                            end else begin
                                wr_cur_q <= wr_commit_q;
                            end
                        end else begin
                            len_q      <= len_d;
                            wr_cur_q   <= wr_cur_q + PW'(1);
                            wr_state_q <= WR_RECV;
                        end
                    end
                    WR_DROP: begin
                        if (rx_axis_tlast) begin
                            wr_state_q <= WR_IDLE;
                        end
                    end
                    default: wr_state_q <= WR_IDLE;
                endcase
            end
        end
    end

    udma_ethernet_len_fifo #(
        .DEPTH   (LEN_FIFO_DEPTH)
    ) u_len_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (commit),
        .data_i  (len_d[10:0]),
        .pop_i   (len_pop),
        .data_o  (len_dout),
        .full_o  (len_full),
        .empty_o (len_empty)
    );

    // Two-stage read pipeline (RAM register, output register) keeps one byte per cycle under backpressure.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_state_q  <= RD_IDLE;
            rd_q        <= '0;
            ram_vld_q   <= 1'b0;
            size_q      <= '0;
            issue_cnt_q <= '0;
            sent_cnt_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: begin
                    if (!len_empty) begin
                        size_q      <= len_dout;
                        start_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        issue_cnt_q <= '0;
                        sent_cnt_q  <= '0;
                        rd_state_q  <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if (rd_issue) begin
                        rd_q        <= rd_q + PW'(1);
                        issue_cnt_q <= issue_cnt_q + 11'd1;
                        ram_vld_q   <= 1'b1;
                    end else if (out_load) begin
                        ram_vld_q <= 1'b0;
                    end
                    if (out_load) begin
                        data_q  <= ram_q;
                        valid_q <= 1'b1;
                    end else if (xfer) begin
                        valid_q <= 1'b0;
                    end
                    if (xfer) begin
                        sent_cnt_q <= sent_cnt_q + 11'd1;
                        if (sent_cnt_q == (size_q - 11'd1)) begin
                            valid_q    <= 1'b0;
                            busy_q     <= 1'b0;
                            rd_state_q <= RD_IDLE;
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udma_ethernet_axis_rx_frame_buffer.sv
// Scoreboard bench for the RX frame buffer: frames expected to survive are queued when sent
// and checked byte-by-byte as the UDMA side consumes them.
module tb_udma_ethernet_axis_rx_frame_buffer;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic [7:0]  rx_axis_tdata  = '0;
    logic        rx_axis_tvalid = 1'b0;
    logic        rx_axis_tready;
    logic        rx_axis_tlast  = 1'b0;
    logic        rx_axis_tuser  = 1'b0;
    logic [7:0]  data_rx_o;
    logic        data_rx_valid_o;
    logic        data_rx_ready_i = 1'b1;
    logic [10:0] rx_transfer_size;
    logic        rx_frame_start_o;
    logic [15:0] rx_drop_cnt_o;
    logic        rx_busy_o;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  exp_bytes [$];
    logic [10:0] exp_size  [$];

    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = '0;

    always #5 clk = ~clk;

    udma_ethernet_axis_rx_frame_buffer #(
        .DATA_WIDTH     (8),
        .BUF_DEPTH      (2048),
        .LEN_FIFO_DEPTH (8),
        .MAX_FRAME_LEN  (1522)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .rx_axis_tdata    (rx_axis_tdata),
        .rx_axis_tvalid   (rx_axis_tvalid),
        .rx_axis_tready   (rx_axis_tready),
        .rx_axis_tlast    (rx_axis_tlast),
        .rx_axis_tuser    (rx_axis_tuser),
        .data_rx_o        (data_rx_o),
        .data_rx_valid_o  (data_rx_valid_o),
        .data_rx_ready_i  (data_rx_ready_i),
        .rx_transfer_size (rx_transfer_size),
        .rx_frame_start_o (rx_frame_start_o),
        .rx_drop_cnt_o    (rx_drop_cnt_o),
        .rx_busy_o        (rx_busy_o)
    );

    // Scoreboard consumer: announced sizes, delivered bytes, and output stability under backpressure.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                compared++;
                if (data_rx_valid_o !== 1'b1 || data_rx_o !== prev_data) begin
                    mismatched++;
                    $display("[TB] FAIL hold_stable: got valid=%0b data=%02h, want valid=1 data=%02h",
                             data_rx_valid_o, data_rx_o, prev_data);
                end
            end
            if (rx_frame_start_o === 1'b1) begin
                compared++;
                if (exp_size.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_frame: got size=%0d, want no frame", rx_transfer_size);
                end else begin
                    logic [10:0] es;
                    es = exp_size.pop_front();
                    if (rx_transfer_size !== es) begin
                        mismatched++;
                        $display("[TB] FAIL transfer_size: got %0d, want %0d", rx_transfer_size, es);
                    end
                end
            end
            if (data_rx_valid_o === 1'b1 && data_rx_ready_i === 1'b1) begin
                compared++;
                if (exp_bytes.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_byte: got %02h, want nothing", data_rx_o);
                end else begin
                    logic [7:0] eb;
                    eb = exp_bytes.pop_front();
                    if (data_rx_o !== eb) begin
                        mismatched++;
                        $display("[TB] FAIL data_byte: got %02h, want %02h", data_rx_o, eb);
                    end
                end
            end
            prev_stall = (data_rx_valid_o === 1'b1) && (data_rx_ready_i !== 1'b1);
            prev_data  = data_rx_o;
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        rstn            = 1'b0;
        rx_axis_tvalid  = 1'b0;
        rx_axis_tlast   = 1'b0;
        rx_axis_tuser   = 1'b0;
        rx_axis_tdata   = '0;
        data_rx_ready_i = 1'b1;
        exp_bytes.delete();
        exp_size.delete();
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input bit err, input logic [7:0] seed, input bit expect_ok);
        if (expect_ok) begin
            exp_size.push_back(11'(len));
            for (int i = 0; i < len; i++) exp_bytes.push_back(8'(seed + i));
        end
        for (int i = 0; i < len; i++) begin
            rx_axis_tvalid = 1'b1;
            rx_axis_tdata  = 8'(seed + i);
            rx_axis_tlast  = (i == len - 1);
            rx_axis_tuser  = err && (i == len - 1);
            @(posedge clk);
            #1;
        end
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
        rx_axis_tuser  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget, output bit seen);
        int n = 0;
        seen = 1'b0;
        while (n < budget && !seen) begin
            @(negedge clk);
            if (rx_frame_start_o === 1'b1) seen = 1'b1;
            n++;
        end
    endtask

    task automatic drain(input int budget, input bit rand_ready, output bit done);
        int n = 0;
        while ((exp_bytes.size() != 0 || exp_size.size() != 0 || rx_busy_o === 1'b1) && n < budget) begin
            if (rand_ready) data_rx_ready_i = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        data_rx_ready_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        done = (n < budget);
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #2;
        compared++;
        if (rx_axis_tready !== 1'b1) begin
            mismatched++; $display("[TB] FAIL reset_tready: got %0b, want 1", rx_axis_tready);
        end
        compared++;
        if (data_rx_valid_o !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_valid: got %0b, want 0", data_rx_valid_o);
        end
        compared++;
        if (rx_frame_start_o !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_start: got %0b, want 0", rx_frame_start_o);
        end
        compared++;
        if (rx_transfer_size !== 11'd0) begin
            mismatched++; $display("[TB] FAIL reset_size: got %0d, want 0", rx_transfer_size);
        end
        compared++;
        if (rx_drop_cnt_o !== 16'd0) begin
            mismatched++; $display("[TB] FAIL reset_drop: got %0d, want 0", rx_drop_cnt_o);
        end
        compared++;
        if (rx_busy_o !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_busy: got %0b, want 0", rx_busy_o);
        end
        do_reset();
    endtask

    task automatic test_single_frame();
        bit seen;
        bit done;
        int run = 0;
        do_reset();
        send_frame(64, 1'b0, 8'h10, 1'b1);
        wait_start(20, seen);
        compared++;
        if (!seen) begin
            mismatched++; $display("[TB] FAIL single_start: got no pulse, want pulse");
        end
        compared++;
        if (rx_busy_o !== 1'b1) begin
            mismatched++; $display("[TB] FAIL single_busy: got %0b, want 1", rx_busy_o);
        end
        @(negedge clk);
        compared++;
        if (data_rx_valid_o !== 1'b0) begin
            mismatched++; $display("[TB] FAIL single_early_valid: got %0b, want 0", data_rx_valid_o);
        end
        @(negedge clk);
        compared++;
        if (data_rx_valid_o !== 1'b1) begin
            mismatched++; $display("[TB] FAIL single_latency: got valid=%0b, want 1", data_rx_valid_o);
        end
        while (data_rx_valid_o === 1'b1 && run < 200) begin
            run++;
            @(negedge clk);
        end
        compared++;
        if (run != 64) begin
            mismatched++; $display("[TB] FAIL single_burst: got %0d consecutive bytes, want 64", run);
        end
        drain(300, 1'b0, done);
        compared++;
        if (!done || exp_bytes.size() != 0) begin
            mismatched++; $display("[TB] FAIL single_drain: got %0d bytes left, want 0", exp_bytes.size());
        end
        compared++;
        if (rx_drop_cnt_o !== 16'd0) begin
            mismatched++; $display("[TB] FAIL single_drop: got %0d, want 0", rx_drop_cnt_o);
        end
    endtask

    task automatic test_error_frame();
        bit done;
        do_reset();
        send_frame(100, 1'b1, 8'h40, 1'b0);
        send_frame(60, 1'b0, 8'h80, 1'b1);
        drain(400, 1'b0, done);
        compared++;
        if (!done || exp_bytes.size() != 0) begin
            mismatched++; $display("[TB] FAIL error_drain: got %0d bytes left, want 0", exp_bytes.size());
        end
        compared++;
        if (rx_drop_cnt_o !== 16'd1) begin
            mismatched++; $display("[TB] FAIL error_drop: got %0d, want 1", rx_drop_cnt_o);
        end
    endtask

    task automatic test_oversize();
        bit done;
        do_reset();
        send_frame(1600, 1'b0, 8'h20, 1'b0);
        send_frame(1, 1'b0, 8'hA5, 1'b1);
        drain(200, 1'b0, done);
        compared++;
        if (!done || exp_size.size() != 0) begin
            mismatched++; $display("[TB] FAIL oversize_drain: got %0d frames left, want 0", exp_size.size());
        end
        compared++;
        if (rx_drop_cnt_o !== 16'd1) begin
            mismatched++; $display("[TB] FAIL oversize_drop: got %0d, want 1", rx_drop_cnt_o);
        end
    endtask

    task automatic test_buffer_overflow();
        bit done;
        do_reset();
        data_rx_ready_i = 1'b0;
        send_frame(1000, 1'b0, 8'h01, 1'b1);
        send_frame(1000, 1'b0, 8'h55, 1'b1);
        send_frame(1000, 1'b0, 8'h99, 1'b0);
        compared++;
        if (rx_drop_cnt_o !== 16'd1) begin
            mismatched++; $display("[TB] FAIL overflow_drop: got %0d, want 1", rx_drop_cnt_o);
        end
        data_rx_ready_i = 1'b1;
        drain(5000, 1'b0, done);
        compared++;
        if (!done || exp_bytes.size() != 0) begin
            mismatched++; $display("[TB] FAIL overflow_drain: got %0d bytes left, want 0", exp_bytes.size());
        end
        compared++;
        if (rx_drop_cnt_o !== 16'd1) begin
            mismatched++; $display("[TB] FAIL overflow_drop_after: got %0d, want 1", rx_drop_cnt_o);
        end
    endtask

    // The reader pulls the first length out of the FIFO at once, so ten frames overfill eight entries.
    task automatic test_len_fifo_full();
        bit done;
        do_reset();
        data_rx_ready_i = 1'b0;
        for (int f = 0; f < 10; f++) begin
            send_frame(10, 1'b0, 8'(f * 16 + 3), (f < 9));
        end
        compared++;
        if (rx_drop_cnt_o !== 16'd1) begin
            mismatched++; $display("[TB] FAIL lenfifo_drop: got %0d, want 1", rx_drop_cnt_o);
        end
        drain(3000, 1'b1, done);
        compared++;
        if (!done || exp_bytes.size() != 0 || exp_size.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL lenfifo_drain: got %0d bytes/%0d frames left, want 0/0",
                     exp_bytes.size(), exp_size.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        bit done;
        do_reset();
        send_frame(200, 1'b0, 8'h33, 1'b1);
        wait_start(20, seen);
        compared++;
        if (!seen) begin
            mismatched++; $display("[TB] FAIL midreset_start: got no pulse, want pulse");
        end
        repeat (40) @(negedge clk);
        compared++;
        if (rx_busy_o !== 1'b1) begin
            mismatched++; $display("[TB] FAIL midreset_busy_before: got %0b, want 1", rx_busy_o);
        end
        #3 rstn = 1'b0;
        #1;
        compared++;
        if (data_rx_valid_o !== 1'b0 || rx_busy_o !== 1'b0 || rx_frame_start_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_flags: got valid=%0b busy=%0b start=%0b, want 0/0/0",
                     data_rx_valid_o, rx_busy_o, rx_frame_start_o);
        end
        compared++;
        if (rx_transfer_size !== 11'd0 || rx_drop_cnt_o !== 16'd0 || rx_axis_tready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midreset_values: got size=%0d drop=%0d tready=%0b, want 0/0/1",
                     rx_transfer_size, rx_drop_cnt_o, rx_axis_tready);
        end
        exp_bytes.delete();
        exp_size.delete();
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        send_frame(32, 1'b0, 8'hC7, 1'b1);
        drain(300, 1'b0, done);
        compared++;
        if (!done || exp_bytes.size() != 0) begin
            mismatched++; $display("[TB] FAIL midreset_drain: got %0d bytes left, want 0", exp_bytes.size());
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_single_frame();
        test_error_frame();
        test_oversize();
        test_buffer_overflow();
        test_len_fifo_full();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
